// File: rtl/dec16_pkg.sv
// Shared types and constants for the streaming 4-to-16 decoder.
// Holds the FSM state type, FIFO entry layout and a reference decode.
package dec16_pkg;

  localparam int CODE_W = 4;
  localparam int LINE_W = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_HOLD
  } state_t;

  typedef struct packed {
    logic [CODE_W-1:0] y;
    logic              z;
  } entry_t;

  function automatic logic [LINE_W-1:0] onehot16(
    input logic [CODE_W-1:0] code,
    input logic              z
  );
    onehot16 = z ? (LINE_W'(1) << code) : '0;
  endfunction

endpackage

// File: rtl/decoder16_stream_dec2to4.sv
// 2-to-4 line decoder with enable.
// Leaf cell of the 4x4 decode tree in decoder16_stream.
module dec2to4 (
  input  logic       en,
  input  logic [1:0] a,
  output logic [3:0] y
);

  // one output line per code, all low when disabled
  always_comb begin
    y = '0;
    if (en) begin
      unique case (a)
        2'd0: y = 4'b0001;
        2'd1: y = 4'b0010;
        2'd2: y = 4'b0100;
        2'd3: y = 4'b1000;
      endcase
    end
  end

endmodule

// File: rtl/decoder16_stream.sv
// Streaming 4-to-16 decoder: FIFO-buffered codes out as one-hot words.
// Optional rate limiting after each output word: define DEC16_HOLD_EN.
module decoder16_stream
  import dec16_pkg::*;
#(
  parameter int FIFO_DEPTH  = 2,
  parameter int HOLD_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_y,
  input  logic              in_z,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LINE_W-1:0] out_w,
  output logic              out_z
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

`ifdef DEC16_HOLD_EN
  localparam bit HOLD_ON = HOLD_CYCLES > 0;
`else
  localparam bit HOLD_ON = 1'b0 && (HOLD_CYCLES > 0);
`endif
  // The final idle cycle is spent in S_IDLE reloading the
  // output register, so S_HOLD covers HOLD_CYCLES-1 cycles.
  localparam bit HOLD_LONG = HOLD_ON && (HOLD_CYCLES > 1);

  entry_t            mem_q [FIFO_DEPTH];
  entry_t            mem_d [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  state_t            state_q, state_d;
  logic [LINE_W-1:0] out_w_q, out_w_d;
  logic              out_z_q, out_z_d;

  logic   full;
  logic   empty;
  logic   push;
  logic   pop;
  entry_t head;

  logic [3:0]        grp;
  logic [LINE_W-1:0] dec_w;

  assign full     = (cnt_q == CW'(FIFO_DEPTH));
  assign empty    = (cnt_q == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign head     = mem_q[rd_ptr_q];

  assign out_valid = (state_q == S_SEND);
  assign out_w     = out_w_q;
  assign out_z     = out_z_q;

  dec2to4 u_grp (
    .en (head.z),
    .a  (head.y[3:2]),
    .y  (grp)
  );

  for (genvar g = 0; g < 4; g++) begin : g_line
    dec2to4 u_line (
      .en (grp[g]),
      .a  (head.y[1:0]),
      .y  (dec_w[4*g +: 4])
    );
  end

`ifdef DEC16_HOLD_EN
  localparam int HW = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam int HOLD_LAST_I = HOLD_LONG ? HOLD_CYCLES - 2 : 0;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_LAST_I);

  logic [HW-1:0] hold_cnt_q, hold_cnt_d;

  // count cycles spent in S_HOLD, cleared elsewhere
  always_comb begin
    hold_cnt_d = '0;
    if (state_q == S_HOLD) hold_cnt_d = hold_cnt_q + HW'(1);
  end

  // hold counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_cnt_q <= '0;
    else        hold_cnt_q <= hold_cnt_d;
  end
`endif

  // FSM next state and FIFO pop decision
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (out_ready) begin
          if (HOLD_LONG)    state_d = S_HOLD;
          else if (HOLD_ON) state_d = S_IDLE;
          else if (!empty)  pop     = 1'b1;
          else              state_d = S_IDLE;
        end
      end
      S_HOLD: begin
`ifdef DEC16_HOLD_EN
        if (hold_cnt_q == HOLD_LAST) state_d = S_IDLE;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // output register loads the decoded head on pop
  always_comb begin
    out_w_d = out_w_q;
    out_z_d = out_z_q;
    if (pop) begin
      out_w_d = dec_w;
      out_z_d = head.z;
    end
  end

  // FIFO storage, pointers and occupancy
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = '{y: in_y, z: in_z};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      out_w_q  <= '0;
      out_z_q  <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      out_w_q  <= out_w_d;
      out_z_q  <= out_z_d;
      mem_q    <= mem_d;
    end
  end

endmodule
